// File: rtl/counter_bus_pkg.sv
// counter_bus_pkg: shared bus widths, FSM encoding and counter-peripheral register map
// for counter_bus_master and its timeout timer.
package counter_bus_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } bus_state_t;

  // Counter peripheral register map
  localparam logic [ADDR_W-1:0] REG_STATUS   = 4'h0;
  localparam logic [ADDR_W-1:0] REG_CTRL     = 4'h1;
  localparam logic [ADDR_W-1:0] REG_LOAD     = 4'h2;
  localparam logic [ADDR_W-1:0] REG_COUNT    = 4'h3;
  localparam logic [ADDR_W-1:0] REG_IRQ_MASK = 4'h4;

  localparam logic [ADDR_W-1:0] IRQ_ADDR_DEFAULT = REG_STATUS;

  function automatic int unsigned timer_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/bus_timeout_timer.sv
// bus_timeout_timer: saturating cycle counter bounding how long a bus select may wait
// for an ack; expired marks the last permitted select cycle.
module bus_timeout_timer
  import counter_bus_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = timer_width(LIMIT);
  localparam logic [CNT_W-1:0] MAX_COUNT  = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != MAX_COUNT)) begin
      count <= count + 1'b1;
    end
  end

  // Count holds N-1 during the N-th select cycle, so flagging here aborts after exactly LIMIT cycles.
  assign expired = enable && (count >= LAST_COUNT);

endmodule

// File: rtl/counter_bus_master.sv
// counter_bus_master: single-transaction bus initiator for the counter peripheral with timeout.
// Optional auto read of IRQ_ADDR on interrupt edges when COUNTER_BUS_MASTER_IRQ_READ_EN is defined.
module counter_bus_master
  import counter_bus_pkg::*;
#(
  parameter int unsigned         TIMEOUT_CYCLES = 255,
  parameter logic [ADDR_W-1:0]   IRQ_ADDR       = IRQ_ADDR_DEFAULT
) (
  input  logic              i_sysclk,
  input  logic              i_sysrst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_wr,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [DATA_W-1:0] i_cmd_data,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_rsp_err,
  output logic              o_rsp_irq,
  output logic              o_bus_select,
  output logic              o_bus_wr,
  output logic [ADDR_W-1:0] o_reg_addr,
  output logic [DATA_W-1:0] o_bus_data,
  input  logic [DATA_W-1:0] i_bus_data,
  input  logic              i_bus_ack,
  input  logic              i_int_flg
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("counter_bus_master: TIMEOUT_CYCLES must be in 1..65535");
  end

  bus_state_t state;

  logic busy;
  logic ack_hit;
  logic timed_out;
  logic start_host;
  logic start_irq;
  logic pending_next;
  logic irq_txn;

  assign busy       = (state == ST_REQ) || (state == ST_WAIT);
  assign ack_hit    = busy && i_bus_ack;
  assign start_host = (state == ST_IDLE) && i_cmd_valid && o_cmd_ready;

`ifdef COUNTER_BUS_MASTER_IRQ_READ_EN
  logic int_flg_q;
  logic irq_pending;
  logic int_rise;

  assign int_rise     = i_int_flg && !int_flg_q;
  assign start_irq    = (state == ST_IDLE) && irq_pending;
  // An edge landing in the same cycle the pending read launches re-arms the flag rather than being lost.
  assign pending_next = (irq_pending && !start_irq) || int_rise;

  always_ff @(posedge i_sysclk or posedge i_sysrst) begin
    if (i_sysrst) begin
      int_flg_q   <= 1'b0;
      irq_pending <= 1'b0;
      irq_txn     <= 1'b0;
    end else begin
      int_flg_q   <= i_int_flg;
      irq_pending <= pending_next;
      if (start_irq) begin
        irq_txn <= 1'b1;
      end else if (start_host) begin
        irq_txn <= 1'b0;
      end
    end
  end
`else
  logic unused_int_flg;

  assign start_irq      = 1'b0;
  assign pending_next   = 1'b0;
  assign irq_txn        = 1'b0;
  assign unused_int_flg = i_int_flg;
`endif

  bus_timeout_timer #(
    .LIMIT   (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (i_sysclk),
    .rst     (i_sysrst),
    .clear   (start_host || start_irq),
    .enable  (busy),
    .expired (timed_out)
  );

  // In IDLE, o_cmd_ready always mirrors !irq_pending, so host and IRQ starts never collide.
  always_ff @(posedge i_sysclk or posedge i_sysrst) begin
    if (i_sysrst) begin
      state        <= ST_IDLE;
      o_cmd_ready  <= 1'b1;
      o_rsp_valid  <= 1'b0;
      o_rsp_data   <= '0;
      o_rsp_err    <= 1'b0;
      o_rsp_irq    <= 1'b0;
      o_bus_select <= 1'b0;
      o_bus_wr     <= 1'b0;
      o_reg_addr   <= '0;
      o_bus_data   <= '0;
    end else begin
      o_rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_irq) begin
            state        <= ST_REQ;
            o_cmd_ready  <= 1'b0;
            o_bus_select <= 1'b1;
            o_bus_wr     <= 1'b0;
            o_reg_addr   <= IRQ_ADDR;
          end else if (start_host) begin
            state        <= ST_REQ;
            o_cmd_ready  <= 1'b0;
            o_bus_select <= 1'b1;
            o_bus_wr     <= i_cmd_wr;
            o_reg_addr   <= i_cmd_addr;
            o_bus_data   <= i_cmd_data;
          end else begin
            o_cmd_ready <= !pending_next;
          end
        end

        ST_REQ, ST_WAIT: begin
          if (ack_hit) begin
            state        <= ST_RESP;
            o_bus_select <= 1'b0;
            o_bus_wr     <= 1'b0;
            o_rsp_valid  <= 1'b1;
            o_rsp_data   <= o_bus_wr ? '0 : i_bus_data;
            o_rsp_err    <= 1'b0;
            o_rsp_irq    <= irq_txn;
          end else if (timed_out) begin
            state        <= ST_RESP;
            o_bus_select <= 1'b0;
            o_bus_wr     <= 1'b0;
            o_rsp_valid  <= 1'b1;
            o_rsp_data   <= '0;
            o_rsp_err    <= 1'b1;
            o_rsp_irq    <= irq_txn;
          end else begin
            state <= ST_WAIT;
          end
        end

        ST_RESP: begin
          state       <= ST_IDLE;
          o_cmd_ready <= !pending_next;
        end

        default: begin
          state        <= ST_IDLE;
          o_cmd_ready  <= 1'b1;
          o_bus_select <= 1'b0;
          o_bus_wr     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_bus_master.sv
// tb_counter_bus_master: directed stimulus with a response scoreboard for counter_bus_master.
`timescale 1ns/1ps
module tb_counter_bus_master;

  localparam int unsigned T = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_wr = 1'b0;
  logic [3:0]  cmd_addr = 4'h0;
  logic [15:0] cmd_data = 16'h0;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        rsp_irq;
  logic        bus_select;
  logic        bus_wr;
  logic [3:0]  reg_addr;
  logic [15:0] bus_data;
  logic [15:0] bus_rdata = 16'h0;
  logic        bus_ack = 1'b0;
  logic        int_flg = 1'b0;

  always #5 clk = ~clk;

  counter_bus_master #(
    .TIMEOUT_CYCLES (T),
    .IRQ_ADDR       (4'h0)
  ) dut (
    .i_sysclk     (clk),
    .i_sysrst     (rst),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_wr     (cmd_wr),
    .i_cmd_addr   (cmd_addr),
    .i_cmd_data   (cmd_data),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_data   (rsp_data),
    .o_rsp_err    (rsp_err),
    .o_rsp_irq    (rsp_irq),
    .o_bus_select (bus_select),
    .o_bus_wr     (bus_wr),
    .o_reg_addr   (reg_addr),
    .o_bus_data   (bus_data),
    .i_bus_data   (bus_rdata),
    .i_bus_ack    (bus_ack),
    .i_int_flg    (int_flg)
  );

  typedef struct {
    logic [15:0] data;
    logic        err;
    logic        irq;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every response strobe must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp: got data %0h err %b, expected no response", rsp_data, rsp_err);
        end else begin
          e = sb.pop_front();
          check({e.name, "_rsp_data"}, 32'(rsp_data), 32'(e.data));
          check({e.name, "_rsp_err"}, 32'(rsp_err), 32'(e.err));
          check({e.name, "_rsp_irq"}, 32'(rsp_irq), 32'(e.irq));
          check({e.name, "_rsp_cycle"}, 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  // ack_dly: select cycle index (0 = first) on which the slave acks; negative = never.
  task automatic do_cmd(input string name, input logic wr, input logic [3:0] addr,
                        input logic [15:0] data, input int ack_dly,
                        input logic [15:0] rdata, input bit chk_b2b);
    int waited;
    int k;
    int exp_k;
    int a;
    bit acked;
    bit fields_ok;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = addr;
    cmd_data  = data;
    bus_rdata = rdata;
    waited    = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (chk_b2b || waited >= 50) check({name, "_ready_wait"}, 32'(waited), 32'd0);
    @(posedge clk); #1;
    a         = cyc;
    cmd_valid = 1'b0;
    cmd_wr    = ~wr;
    cmd_addr  = ~addr;
    cmd_data  = ~data;
    acked     = (ack_dly >= 0) && (ack_dly < int'(T));
    exp_k     = acked ? ack_dly + 1 : int'(T);
    sb.push_back('{data: (wr || !acked) ? 16'h0 : rdata, err: !acked, irq: 1'b0,
                   cyc: a + exp_k, name: name});
    k         = 0;
    fields_ok = 1'b1;
    repeat (T + 4) begin
      bus_ack = (k == ack_dly);
      @(negedge clk);
      if (bus_select !== 1'b1) break;
      k++;
      if (bus_wr !== wr || reg_addr !== addr || bus_data !== data || cmd_ready !== 1'b0)
        fields_ok = 1'b0;
      @(posedge clk); #1;
    end
    bus_ack = 1'b0;
    check({name, "_select_cycles"}, 32'(k), 32'(exp_k));
    check({name, "_bus_fields_stable"}, 32'(fields_ok), 32'd1);
    check({name, "_resp_ready_low"}, 32'(cmd_ready), 32'd0);
    check({name, "_resp_wr_low"}, 32'(bus_wr), 32'd0);
    check({name, "_bus_data_held"}, 32'(bus_data), 32'(data));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset_select", 32'(bus_select), 32'd0);
    check("reset_wr", 32'(bus_wr), 32'd0);
    check("reset_addr", 32'(reg_addr), 32'd0);
    check("reset_bus_data", 32'(bus_data), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    check("reset_rsp_irq", 32'(rsp_irq), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    do_cmd("wr_fast", 1'b1, 4'h2, 16'h1234, 0, 16'hFFFF, 1'b0);
    do_cmd("rd_slow", 1'b0, 4'h5, 16'h0000, 4, 16'hBEEF, 1'b0);
    do_cmd("rd_timeout", 1'b0, 4'h9, 16'h0001, -1, 16'hDEAD, 1'b0);
    do_cmd("rd_after_to", 1'b0, 4'hA, 16'h0002, 1, 16'h0042, 1'b0);
    do_cmd("rd_ack_last", 1'b0, 4'h3, 16'h0003, int'(T) - 1, 16'hCAFE, 1'b0);
    do_cmd("rd_ack_late", 1'b0, 4'h4, 16'h0004, int'(T), 16'h7777, 1'b0);

    // Spurious ack while idle must not start anything.
    @(posedge clk); #1 bus_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_ack_select", 32'(bus_select), 32'd0);
      check("idle_ack_ready", 32'(cmd_ready), 32'd1);
    end
    @(posedge clk); #1 bus_ack = 1'b0;

    // Reset during WAIT: select drops asynchronously, no response follows.
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 4'h7; cmd_data = 16'h4321;
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("wait_select_before_rst", 32'(bus_select), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_async_select", 32'(bus_select), 32'd0);
    check("rst_async_wr", 32'(bus_wr), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(cmd_ready), 32'd1);
    check("post_rst_select", 32'(bus_select), 32'd0);

    do_cmd("b2b_first", 1'b1, 4'hF, 16'hA5A5, 2, 16'h0000, 1'b0);
    do_cmd("b2b_second", 1'b0, 4'h1, 16'h0000, 0, 16'h1357, 1'b1);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
